// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, GF(2^8) helpers and the iterative-stage FSM encoding.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using chained xtime; covers 01,02,03,09,0b,0d,0e.
  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] b,
                                             input logic [3:0]        k);
    logic [BYTE_W-1:0] x2;
    logic [BYTE_W-1:0] x4;
    logic [BYTE_W-1:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns transform.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] s_s [4];
  logic [3:0]        k_s [4];

  // Apply the circulant matrix: row r uses coefficient k[j] on byte (r+j) mod 4.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      s_s[r] = col_i[COL_W-1-BYTE_W*r -: BYTE_W];
    end
    if (inv_i) begin
      k_s[0] = 4'hE;
      k_s[1] = 4'hB;
      k_s[2] = 4'hD;
      k_s[3] = 4'h9;
    end else begin
      k_s[0] = 4'h2;
      k_s[1] = 4'h3;
      k_s[2] = 4'h1;
      k_s[3] = 4'h1;
    end
    for (int r = 0; r < 4; r++) begin
      col_o[COL_W-1-BYTE_W*r -: BYTE_W] = gmul(s_s[r],           k_s[0]) ^
                                          gmul(s_s[(r + 1) % 4], k_s[1]) ^
                                          gmul(s_s[(r + 2) % 4], k_s[2]) ^
                                          gmul(s_s[(r + 3) % 4], k_s[3]);
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns stage: transforms COLS_PER_CYCLE columns per clock (legal: 1, 2, 4)
// with valid/ready on both sides and a per-transaction bypass for the final round.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  // Counter step wraps to 0 for COLS_PER_CYCLE=4, which is harmless: BUSY exits after one cycle.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  mc_state_e          state_q,     state_d;
  logic [STATE_W-1:0] work_q,      work_d;
  logic               inv_q,       inv_d;
  logic [1:0]         cnt_q,       cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [COL_W-1:0]   cols_s     [4];
  logic [COL_W-1:0]   unit_in_s  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   unit_out_s [COLS_PER_CYCLE];
  logic [STATE_W-1:0] work_mixed_s;

  // Split the working state into its four columns (column 0 in the MSBs).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols_s[c] = work_q[STATE_W-1-COL_W*c -: COL_W];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    logic [1:0] col_idx_s;
    assign col_idx_s    = cnt_q + 2'(g);
    assign unit_in_s[g] = cols_s[col_idx_s];

    mix_column_unit u_mcu (
      .col_i (unit_in_s[g]),
      .inv_i (inv_q),
      .col_o (unit_out_s[g])
    );
  end

  // Write the transformed columns back in place; untouched columns keep their value.
  always_comb begin
    work_mixed_s = work_q;
    for (int c = 0; c < 4; c++) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        if (cnt_q + 2'(g) == 2'(c)) begin
          work_mixed_s[STATE_W-1-COL_W*c -: COL_W] = unit_out_s[g];
        end else begin
          work_mixed_s[STATE_W-1-COL_W*c -: COL_W] = work_mixed_s[STATE_W-1-COL_W*c -: COL_W];
        end
      end
    end
  end

  // Next-state logic: acceptance, column iteration and output handshake.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    inv_d    = inv_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = 2'd0;
          state_d = in_bypass ? DONE : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d = work_mixed_s;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      DONE: begin
        // Accepting while the result drains gives back-to-back throughput.
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = 2'd0;
          state_d = in_bypass ? DONE : BUSY;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State, working register and registered valid; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      inv_q       <= 1'b0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter with COLS_PER_CYCLE = 1, 2 and 4 instances.
module tb_mix_columns_iter;

  localparam int NDUT = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NDUT-1:0]     in_valid;
  logic [NDUT-1:0]     in_inv;
  logic [NDUT-1:0]     in_bypass;
  logic [NDUT-1:0]     out_ready;
  logic [127:0]        in_state  [NDUT];
  wire  [NDUT-1:0]     in_ready;
  wire  [NDUT-1:0]     out_valid;
  wire  [127:0]        out_state [NDUT];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] ST1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] EXP1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] ST3  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] EXP3 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  // Reference GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] ref_gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] st, input logic inv, input logic byp);
    logic [7:0]   coef [4];
    logic [7:0]   s    [4];
    logic [7:0]   o;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = st;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) s[r] = st[127 - 32*c - 8*r -: 8];
        for (int r = 0; r < 4; r++) begin
          o = 8'h00;
          for (int j = 0; j < 4; j++) o = o ^ ref_gm(coef[(j - r + 4) % 4], s[j]);
          res[127 - 32*c - 8*r -: 8] = o;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on DUT k and check latency and result.
  task automatic send(input int k, input logic [127:0] st, input logic inv, input logic byp,
                      input logic [127:0] exp, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    in_state[k]  = st;
    in_inv[k]    = inv;
    in_bypass[k] = byp;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b1;
    #1;
    check({tag, "_ready"}, 128'(in_ready[k]), 128'(1));
    exp_q.push_back(exp);
    @(negedge clk);
    // Post-acceptance input changes must be ignored.
    in_valid[k]  = 1'b0;
    in_bypass[k] = ~byp;
    in_inv[k]    = ~inv;
    in_state[k]  = ~st;
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, out_state[k], pop_exp());
    in_bypass[k] = 1'b0;
  endtask

  logic [127:0] rs [8];
  logic         rinv [8];

  initial begin
    int lat;
    int sent;
    int got;
    int cyc;
    int last;
    bit acc;

    rst       = 1'b1;
    in_valid  = '0;
    in_inv    = '0;
    in_bypass = '0;
    out_ready = '1;
    for (int k = 0; k < NDUT; k++) in_state[k] = '0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_valid%0d", k), 128'(out_valid[k]), 128'(0));
      check($sformatf("rst_state%0d", k), out_state[k], 128'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready0", 128'(in_ready[0]), 128'(1));

    // Forward and inverse on each width.
    send(0, ST1,  1'b0, 1'b0, EXP1, 5, "fwd_c1");
    send(0, EXP1, 1'b1, 1'b0, ST1,  5, "inv_c1");
    send(1, ST1,  1'b0, 1'b0, EXP1, 3, "fwd_c2");
    send(1, EXP1, 1'b1, 1'b0, ST1,  3, "inv_c2");
    send(2, ST1,  1'b0, 1'b0, EXP1, 2, "fwd_c4");
    send(2, EXP1, 1'b1, 1'b0, ST1,  2, "inv_c4");
    send(0, ST3,  1'b0, 1'b0, EXP3, 5, "fwd_v3");
    send(0, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 1'b1,
         128'h0123456789abcdef_fedcba9876543210, 1, "byp_c1");
    send(2, 128'hdeadbeef_00112233_44556677_8899aabb, 1'b1, 1'b1,
         128'hdeadbeef_00112233_44556677_8899aabb, 1, "byp_c4");

    // Backpressure: hold the result, then drain and accept on the same edge.
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_state[0]  = ST1;
    in_inv[0]    = 1'b0;
    in_valid[0]  = 1'b1;
    exp_q.push_back(EXP1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (out_valid[0] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 128'(lat), 128'(5));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_state[0] = 128'(i) * 128'h1111;
      in_inv[0]   = i[0];
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_state", out_state[0], EXP1);
      check("bp_ready", 128'(in_ready[0]), 128'(0));
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_state[0]  = ST3;
    in_inv[0]    = 1'b0;
    #1;
    check("bp_rel_ready", 128'(in_ready[0]), 128'(1));
    check("bp_rel_data", out_state[0], pop_exp());
    exp_q.push_back(EXP3);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_next_busy", 128'(out_valid[0]), 128'(0));
    lat = 1;
    while (out_valid[0] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_lat", 128'(lat), 128'(5));
    check("bp_next_data", out_state[0], pop_exp());

    // Streaming: 8 random states, in_valid and out_ready held high.
    for (int i = 0; i < 8; i++) begin
      rs[i]   = {$urandom, $urandom, $urandom, $urandom};
      rinv[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; cyc = 0; last = 0; acc = 1'b0;
    @(negedge clk);
    in_state[0] = rs[0];
    in_inv[0]   = rinv[0];
    in_valid[0] = 1'b1;
    while (got < 8 && cyc < 200) begin
      #1;
      if (out_valid[0] === 1'b1) begin
        check($sformatf("str_data%0d", got), out_state[0], pop_exp());
        if (got > 0) check($sformatf("str_gap%0d", got), 128'(cyc - last), 128'(5));
        last = cyc;
        got++;
      end
      if (in_valid[0] && in_ready[0] === 1'b1) begin
        exp_q.push_back(ref_model(rs[sent], rinv[sent], 1'b0));
        sent++;
        acc = 1'b1;
      end else begin
        acc = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (sent < 8) begin
          in_state[0] = rs[sent];
          in_inv[0]   = rinv[sent];
        end else begin
          in_valid[0] = 1'b0;
        end
      end
    end
    in_valid[0] = 1'b0;
    check("str_count", 128'(got), 128'(8));
    exp_q.delete();

    // Reset in the middle of BUSY, after two columns.
    @(negedge clk);
    @(negedge clk);
    in_state[0] = ST1;
    in_inv[0]   = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_state", out_state[0], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 128'(in_ready[0]), 128'(1));
    send(0, ST3, 1'b0, 1'b0, EXP3, 5, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative AES MixColumns/InvMixColumns stage. Sits directly downstream of shiftRows in the round datapath and feeds AddRoundKey.
- Processes COLS_PER_CYCLE 32-bit columns per clock and uses a valid/ready handshake on both sides.
- A per-transaction bypass flag lets the final cipher round pass the state through unchanged.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4. Processing cycles N = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state, in_inv and in_bypass are valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_state  input  128  state from shiftRows.
- in_inv  input  1  1 selects InvMixColumns, 0 selects MixColumns.
- in_bypass  input  1  1 passes the state through untransformed (last round).
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  transformed state.

Behaviour:
- Byte layout is column-major, byte 0 at [127:120].
  - Column c occupies [127-32c -: 32].
  - Row r within column c is [127-32c-8r -: 8].
- MixColumns per column: s'0=2s0^3s1^s2^s3, with the matrix rotated per row. GF(2^8) polynomial is 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- InvMixColumns uses the coefficients {0e,0b,0d,09}, built from chained xtime.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, capture in_state, in_inv and in_bypass into the working register and clear the column counter. If in_bypass=1, go to DONE; otherwise go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, replace columns cnt .. cnt+COLS_PER_CYCLE-1 in place and add COLS_PER_CYCLE to cnt. The cycle that processes the last column moves to DONE.
  - DONE: out_valid=1 and out_state is the working register.
    - out_ready=0: hold. out_state must stay stable.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: accept the new transaction in the same cycle (in_ready = out_ready in DONE) and go to BUSY, or to DONE if bypassed. This gives back-to-back throughput with no idle bubble.
- Latency, measured from the accepting edge to the first cycle out_valid=1:
  - N+1 cycles normally: 5, 3 or 2 for COLS_PER_CYCLE = 1, 2, 4.
  - 1 cycle when bypassed.
- in_ready is a function of the FSM state and out_ready only. It never depends on in_valid.
- The column counter is 2 bits wide. No wrap-around beyond column 3 occurs because BUSY exits on the last column.
- in_inv and in_bypass are sampled only at acceptance. Input changes while BUSY or DONE are ignored.
- Reset, asserted at any time including mid-transaction:
  - State goes to IDLE and the in-flight transaction is dropped.
  - out_valid=0 and out_state=128'h0; the working register and counter are cleared.
  - in_ready reads 1 once reset deasserts.

Decomposition:
- Shared AES package (aes_pkg) holds:
  - AES_POLY = 8'h1B;
  - the state/column/byte width constants 128/32/8;
  - xtime and gmul functions over GF(2^8);
  - the FSM state enum {IDLE, BUSY, DONE}.
- One sub-module, mix_column_unit: combinational 32-bit column transform with an inv select. It is instantiated COLS_PER_CYCLE times, and the column mux and FSM stay in mix_columns_iter.

Test Plan:
1. Forward, COLS_PER_CYCLE=1: column 0 = db 13 53 45, cols 1-3 = f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6 -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid rising 5 cycles after acceptance.
2. Inverse: in_inv=1 with the scenario 1 result as input -> returns db135345_f20a225c_01010101_c6c6c6c6. Repeat for COLS_PER_CYCLE = 2 and 4, checking latency 3 and 2.
3. Forward with columns d4d4d4d5 and 2d26314c in cols 0 and 1 -> d5d5d7d6 and 4d7ebdf8. Then in_bypass=1 with an arbitrary state -> identical state out after 1 cycle.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0. Release with in_valid=1 -> result consumed and new state accepted on the same edge.
5. Streaming: 8 random states with in_valid and out_ready held high -> results match the reference model in order, with one result every N+1 cycles and no gaps or drops.
6. Reset mid-BUSY (after 2 columns): assert rst asynchronously -> out_valid=0 and out_state=0 immediately. After release, in_ready=1, and a fresh transaction gives the correct result.
